// File: rtl/adxl_fifo_pkg.sv
// Shared defaults, axis indices and the sample left-justify helper for the
// accelerometer frame FIFO.
package adxl_fifo_pkg;

  localparam int N_CH_DEF       = 3;
  localparam int IN_WIDTH_DEF   = 20;
  localparam int OUT_WIDTH_DEF  = 24;
  localparam int ADDR_WIDTH_DEF = 4;

  // Axis order inside a frame; channel 0 sits in the frame LSBs.
  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_e;

  // Widest sample/word the helper handles.
  localparam int PAD_MAX = 64;

  // Left-justify an in_w-bit sample (zero-extended into the argument) into an
  // out_w-bit word, zero filling the low bits. Caller truncates to out_w.
  function automatic logic [PAD_MAX-1:0] pad_sample(
    input logic [PAD_MAX-1:0] sample,
    input int unsigned        in_w,
    input int unsigned        out_w
  );
    return sample << (out_w - in_w);
  endfunction

endpackage

// File: rtl/adxl_fifo_mem.sv
// Frame storage: one full multi-axis frame per entry, synchronous write and
// asynchronous read so the parent can select the channel combinationally.
module adxl_fifo_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 60
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  // Store the incoming frame at the write address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adxl_axis_frame_fifo.sv
// Multi-axis frame FIFO between the decimation filter and the register file.
// One frame (N_CH samples) is written per wr_en; the register side pops one
// left-justified axis word per rising edge of reg_fifo_read_en.
//
// Read handshake: reg_fifo_read_en is a level; its rising edge is a pop
// request. A pop on a non-empty FIFO produces exactly one fifo_reg_data_valid
// pulse on the following cycle carrying fifo_reg_data/fifo_reg_ch. A pop on an
// empty FIFO produces no pulse and sets the sticky udf flag. There is no
// back-pressure on the output.
module adxl_axis_frame_fifo
  import adxl_fifo_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [N_CH*IN_WIDTH-1:0]   filter_fifo_data,
  input  logic                       reg_fifo_read_en,
  input  logic                       flush,
  input  logic                       overwrite_mode,
  input  logic [ADDR_WIDTH:0]        wm_level,
  input  logic                       flag_clr,
  output logic [OUT_WIDTH-1:0]       fifo_reg_data,
  output logic                       fifo_reg_data_valid,
  output logic [$clog2(N_CH)-1:0]    fifo_reg_ch,
  output logic [ADDR_WIDTH:0]        fifo_frame_num,
  output logic                       full,
  output logic                       empty,
  output logic                       wm_flag,
  output logic                       ovf,
  output logic                       udf
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CH_W    = $clog2(N_CH);
  localparam int FRAME_W = N_CH * IN_WIDTH;
  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [PTR_W-1:0]    wr_ptr, rd_ptr, count, count_next;
  logic [CH_W-1:0]     rd_ch, rd_ch_next;
  logic                rd_req_d;
  logic [FRAME_W-1:0]  rd_frame;
  logic [IN_WIDTH-1:0] sample;

  logic pop, do_pop, frame_done, do_wr, wr_accept;
  logic ovf_set, udf_set, ow_adv, rd_adv;

  // Pointer MSBs only carry the lap bit; occupancy comes from the count.
  logic ptr_msb_unused;
  assign ptr_msb_unused = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

  adxl_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (FRAME_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (filter_fifo_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_frame)
  );

  assign sample         = rd_frame[int'(rd_ch)*IN_WIDTH +: IN_WIDTH];
  assign fifo_frame_num = count;
  assign full           = (count == PTR_W'(DEPTH));
  assign empty          = (count == '0);
  assign wm_flag        = (count >= wm_level);

  // Decode pop/write events and the next read-channel state.
  always_comb begin
    pop        = reg_fifo_read_en & ~rd_req_d;
    do_pop     = pop & ~empty & ~flush;
    frame_done = do_pop & (rd_ch == LAST_CH);
    do_wr      = wr_en & ~flush;
    // A same-cycle frame-completing pop frees a slot, so a full write is fine.
    ovf_set    = do_wr & full & ~frame_done;
    ow_adv     = ovf_set & overwrite_mode;
    wr_accept  = do_wr & (~full | frame_done | overwrite_mode);
    udf_set    = pop & empty & ~flush;
    rd_adv     = frame_done | ow_adv;

    rd_ch_next = rd_ch;
    if (flush || ow_adv) begin
      // Overwrite discards the partially read oldest frame whole.
      rd_ch_next = '0;
    end else if (do_pop) begin
      rd_ch_next = (rd_ch == LAST_CH) ? '0 : rd_ch + CH_W'(1);
    end

    count_next = count;
    case ({wr_accept, rd_adv})
      2'b10:   count_next = count + PTR_W'(1);
      2'b01:   count_next = count - PTR_W'(1);
      default: count_next = count;
    endcase
  end

  // Delay the read request for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_req_d <= 1'b0;
    else        rd_req_d <= reg_fifo_read_en;
  end

  // Read-channel state register (state value is the axis being read).
  always_ff @(posedge clk) begin
    if (!rst_n) rd_ch <= '0;
    else        rd_ch <= rd_ch_next;
  end

  // Frame pointers and the authoritative frame count.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Registered output word, its axis index and the one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_reg_data       <= '0;
      fifo_reg_ch         <= '0;
      fifo_reg_data_valid <= 1'b0;
    end else begin
      fifo_reg_data_valid <= do_pop;
      if (do_pop) begin
        fifo_reg_data <= OUT_WIDTH'(pad_sample(PAD_MAX'(sample), IN_WIDTH, OUT_WIDTH));
        fifo_reg_ch   <= rd_ch;
      end
    end
  end

  // Sticky flags; a set in the same cycle as flag_clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~flag_clr);
      udf <= udf_set | (udf & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_adxl_axis_frame_fifo.sv
// Directed bench for the multi-axis frame FIFO.
module tb_adxl_axis_frame_fifo;
  import adxl_fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [59:0] filter_fifo_data;
  logic        reg_fifo_read_en;
  logic        flush;
  logic        overwrite_mode;
  logic [4:0]  wm_level;
  logic        flag_clr;
  logic [23:0] fifo_reg_data;
  logic        fifo_reg_data_valid;
  logic [1:0]  fifo_reg_ch;
  logic [4:0]  fifo_frame_num;
  logic        full, empty, wm_flag, ovf, udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adxl_axis_frame_fifo dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wr_en               (wr_en),
    .filter_fifo_data    (filter_fifo_data),
    .reg_fifo_read_en    (reg_fifo_read_en),
    .flush               (flush),
    .overwrite_mode      (overwrite_mode),
    .wm_level            (wm_level),
    .flag_clr            (flag_clr),
    .fifo_reg_data       (fifo_reg_data),
    .fifo_reg_data_valid (fifo_reg_data_valid),
    .fifo_reg_ch         (fifo_reg_ch),
    .fifo_frame_num      (fifo_frame_num),
    .full                (full),
    .empty               (empty),
    .wm_flag             (wm_flag),
    .ovf                 (ovf),
    .udf                 (udf)
  );

  // ---------------- expected-value helpers ----------------
  function automatic logic [59:0] make_frame(input int n);
    return {20'(n + 'h200), 20'(n + 'h100), 20'(n)};
  endfunction

  // Word for frame n, axis c: sample (n + c*0x100) left-justified by 4 bits.
  function automatic logic [23:0] exp_word(input int n, input int c);
    return 24'((n + c * 'h100) * 16);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic write_frame(input logic [59:0] d);
    wr_en = 1'b1;
    filter_fifo_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [23:0] exp_d, input logic [1:0] exp_c);
    reg_fifo_read_en = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, 64'(fifo_reg_data_valid), 64'(1));
    check({tag, "_data"},  64'(fifo_reg_data),       64'(exp_d));
    check({tag, "_ch"},    64'(fifo_reg_ch),         64'(exp_c));
    reg_fifo_read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic flush_clear();
    flush = 1'b1;
    flag_clr = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    flag_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;
    rst_n = 1'b0;
    wr_en = 1'b0;
    filter_fifo_data = '0;
    reg_fifo_read_en = 1'b0;
    flush = 1'b0;
    overwrite_mode = 1'b0;
    wm_level = 5'd4;
    flag_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_frame_num", 64'(fifo_frame_num), 64'(0));
    check("rst_empty",     64'(empty), 64'(1));
    check("rst_full",      64'(full), 64'(0));
    check("rst_valid",     64'(fifo_reg_data_valid), 64'(0));
    check("rst_data",      64'(fifo_reg_data), 64'(0));
    check("rst_ovf",       64'(ovf), 64'(0));
    check("rst_udf",       64'(udf), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three frames {Z=3,Y=2,X=1}, nine pops
    repeat (3) write_frame(60'h00003_00002_00001);
    check("t1_frame_num", 64'(fifo_frame_num), 64'(3));
    for (int i = 0; i < 9; i++) begin
      logic [23:0] w [3];
      w[0] = 24'h000010; w[1] = 24'h000020; w[2] = 24'h000030;
      pop_check($sformatf("t1_pop%0d", i), w[i % 3], 2'(i % 3));
    end
    check("t1_valid_drop", 64'(fifo_reg_data_valid), 64'(0));
    check("t1_empty", 64'(empty), 64'(1));
    check("t1_udf",   64'(udf), 64'(0));

    // 2: held request pops once
    write_frame(make_frame(0));
    write_frame(make_frame(1));
    pulses = 0;
    reg_fifo_read_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_reg_data_valid) pulses++;
    end
    reg_fifo_read_en = 1'b0;
    @(negedge clk);
    check("t2_pulses",    64'(pulses), 64'(1));
    check("t2_frame_num", 64'(fifo_frame_num), 64'(2));
    flush_clear();
    check("t2_flush_empty", 64'(empty), 64'(1));
    check("t2_flush_num",   64'(fifo_frame_num), 64'(0));

    // 3: overwrite when full
    overwrite_mode = 1'b1;
    for (int n = 0; n < 16; n++) write_frame(make_frame(n));
    check("t3_full_before", 64'(full), 64'(1));
    check("t3_ovf_before",  64'(ovf), 64'(0));
    write_frame(make_frame(16));
    check("t3_full_after", 64'(full), 64'(1));
    check("t3_ovf",        64'(ovf), 64'(1));
    check("t3_frame_num",  64'(fifo_frame_num), 64'(16));
    pop_check("t3_first", exp_word(1, 0), AX_X);
    flush_clear();
    check("t3_ovf_cleared", 64'(ovf), 64'(0));
    check("t3_empty",       64'(empty), 64'(1));

    // 4: drop new when full
    overwrite_mode = 1'b0;
    for (int n = 0; n < 16; n++) write_frame(make_frame(n));
    write_frame(make_frame(16));
    check("t4_ovf",       64'(ovf), 64'(1));
    check("t4_frame_num", 64'(fifo_frame_num), 64'(16));
    for (int n = 0; n < 16; n++)
      for (int c = 0; c < 3; c++)
        pop_check($sformatf("t4_f%0d_c%0d", n, c), exp_word(n, c), 2'(c));
    check("t4_empty", 64'(empty), 64'(1));
    flush_clear();

    // 5: watermark
    wm_level = 5'd4;
    repeat (3) write_frame(make_frame(7));
    check("t5_wm_3", 64'(wm_flag), 64'(0));
    write_frame(make_frame(7));
    check("t5_wm_4", 64'(wm_flag), 64'(1));
    pop_check("t5_p0", exp_word(7, 0), AX_X);
    pop_check("t5_p1", exp_word(7, 1), AX_Y);
    check("t5_wm_partial", 64'(wm_flag), 64'(1));
    pop_check("t5_p2", exp_word(7, 2), AX_Z);
    check("t5_wm_after", 64'(wm_flag), 64'(0));
    flush_clear();
    wm_level = 5'd0;
    @(negedge clk);
    check("t5_wm_zero", 64'(wm_flag), 64'(1));
    wm_level = 5'd4;

    // 6: underflow, then write + frame-completing pop when full
    reg_fifo_read_en = 1'b1;
    @(negedge clk);
    check("t6_udf_valid", 64'(fifo_reg_data_valid), 64'(0));
    check("t6_udf",       64'(udf), 64'(1));
    reg_fifo_read_en = 1'b0;
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("t6_udf_clr", 64'(udf), 64'(0));
    for (int n = 0; n < 16; n++) write_frame(make_frame(n));
    pop_check("t6_p0", exp_word(0, 0), AX_X);
    pop_check("t6_p1", exp_word(0, 1), AX_Y);
    wr_en = 1'b1;
    filter_fifo_data = make_frame(16);
    reg_fifo_read_en = 1'b1;
    @(negedge clk);
    check("t6_both_valid", 64'(fifo_reg_data_valid), 64'(1));
    check("t6_both_data",  64'(fifo_reg_data), 64'(exp_word(0, 2)));
    check("t6_both_num",   64'(fifo_frame_num), 64'(16));
    check("t6_both_ovf",   64'(ovf), 64'(0));
    wr_en = 1'b0;
    reg_fifo_read_en = 1'b0;
    @(negedge clk);
    pop_check("t6_next", exp_word(1, 0), AX_X);

    // Reset in the middle of a frame read
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_num",   64'(fifo_frame_num), 64'(0));
    check("rst2_valid", 64'(fifo_reg_data_valid), 64'(0));
    check("rst2_data",  64'(fifo_reg_data), 64'(0));
    write_frame(make_frame(5));
    pop_check("rst2_pop", exp_word(5, 0), AX_X);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
